clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 175 +++++++++++++++++
 tb/tb_clock_period_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures the high and low phase lengths of a slow, asynchronous, clock-like
// input in clk_in cycles. sig_in is synchronized, edges are detected on the
// synchronized copy, and a three-state FSM counts each phase. A result is
// published, with a one-cycle valid pulse, on every rise that closes a fully
// observed high+low period. A phase that saturates its counter raises a
// sticky timeout, and the meter then waits for a fresh rise.
module clock_period_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] low_time,
  output logic [CNT_WIDTH:0]   period,
  output logic                 valid,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Synchronizer and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  // fill_q shifts in ones after reset. Its top bit is set once s_d holds a
  // genuine sample of sig_in rather than a reset zero. A rise seen before
  // that moment may be the release of reset over an already-high input, so
  // the phase it starts is truncated and must never be published.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   primed;

  // Measurement state
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   hi_lat_q, hi_lat_d;
  logic                   trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   sat;
  logic                   capture;
  logic                   to_set;

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign primed = fill_q[SYNC_STAGES];

  // Synchronizer chain, one-cycle delayed copy, and the priming shift register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      fill_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a real shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The counter saturates rather than wrapping, even where the FSM already
  // leaves the phase on saturation, so no path can ever roll it over.
  assign sat     = (cnt_q == CNT_MAX);
  assign cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;

  // Next-state logic: phase tracking, latching and timeout decision
  always_comb begin
    // NOTE: every variable written here receives a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    trunc_d  = trunc_q;
    capture  = 1'b0;
    to_set   = 1'b0;

    unique case (state_q)
      WAIT_RISE: begin
        // A fall here is ignored: a period is only timed from a rise.
        if (rise) begin
          state_d = MEAS_HIGH;
          cnt_d   = CNT_ONE;
          trunc_d = ~primed;
        end
      end

      MEAS_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = CNT_ONE;
          state_d  = MEAS_LOW;
        end else if (sat) begin
          state_d = WAIT_RISE;
          to_set  = 1'b1;
          trunc_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      MEAS_LOW: begin
        if (rise) begin
          // This rise both closes the current period and opens the next one.
          capture = ~trunc_q;
          trunc_d = 1'b0;
          cnt_d   = CNT_ONE;
          state_d = MEAS_HIGH;
        end else if (sat) begin
          state_d = WAIT_RISE;
          to_set  = 1'b1;
          trunc_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = WAIT_RISE;
        trunc_d = 1'b0;
      end
    endcase
  end

  // State register for the FSM and its phase counter
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RISE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      trunc_q  <= trunc_d;
    end
  end

  // Registered results: updated only on a capture and held in between.
  // timeout is sticky until the next published period clears it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        high_time <= hi_lat_q;
        low_time  <= cnt_q;
        period    <= (CNT_WIDTH+1)'(hi_lat_q) + (CNT_WIDTH+1)'(cnt_q);
        timeout   <= 1'b0;
      end else if (to_set) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter. Three instances share one sig_in: defaults,
// SYNC_STAGES = 3, and CNT_WIDTH = 4. Each segment builds a waveform as a
// list of per-cycle input samples. The expected outputs are derived from the
// edge positions in that list: a period closes at a rise whose preceding fall
// and rise are both known, the first rise after reset only counts if the
// input was low before it, and a phase longer than the counter maximum times
// out. All results appear SYNC_STAGES cycles after the raw edge is sampled.
module tb_clock_period_meter;

  localparam int MAXC = 2048;
  localparam int S_OF[3]   = '{2, 3, 2};
  localparam int MAX_OF[3] = '{65535, 65535, 15};

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic sig_in = 1'b0;

  logic [15:0] ht_a, lt_a, ht_b, lt_b;
  logic [16:0] pd_a, pd_b;
  logic [3:0]  ht_c, lt_c;
  logic [4:0]  pd_c;
  logic        v_a, v_b, v_c, to_a, to_b, to_c;

  clock_period_meter u_def (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .high_time(ht_a), .low_time(lt_a), .period(pd_a), .valid(v_a), .timeout(to_a)
  );

  clock_period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(3)) u_sync3 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .high_time(ht_b), .low_time(lt_b), .period(pd_b), .valid(v_b), .timeout(to_b)
  );

  clock_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) u_cnt4 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .high_time(ht_c), .low_time(lt_c), .period(pd_c), .valid(v_c), .timeout(to_c)
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] o_ht[3], o_lt[3], o_pd[3];
  logic        o_v[3], o_to[3];
  assign o_ht[0] = 32'(ht_a); assign o_lt[0] = 32'(lt_a); assign o_pd[0] = 32'(pd_a);
  assign o_ht[1] = 32'(ht_b); assign o_lt[1] = 32'(lt_b); assign o_pd[1] = 32'(pd_b);
  assign o_ht[2] = 32'(ht_c); assign o_lt[2] = 32'(lt_c); assign o_pd[2] = 32'(pd_c);
  assign o_v[0] = v_a; assign o_v[1] = v_b; assign o_v[2] = v_c;
  assign o_to[0] = to_a; assign o_to[1] = to_b; assign o_to[2] = to_c;

  int checks = 0;
  int errors = 0;

  // Waveform: wave[k] is the sig_in value sampled at rising edge k after
  // reset release; wave[0] stands for the zero the synchronizer holds.
  int wave[MAXC];
  int n_cyc;

  // Expected events per instance, indexed by the cycle they become visible
  bit ev_v[3][MAXC];
  int ev_hi[3][MAXC];
  int ev_lo[3][MAXC];
  bit ev_to[3][MAXC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic new_wave();
    n_cyc   = 0;
    wave[0] = 0;
  endtask

  task automatic add_phase(input int val, input int len);
    for (int j = 0; j < len; j++) begin
      n_cyc++;
      wave[n_cyc] = val;
    end
  endtask

  task automatic build_model(input int inst);
    int edges[$];
    int s, mx, e, nxt, r, f;
    bit tracked;
    s  = S_OF[inst];
    mx = MAX_OF[inst];
    for (int c = 0; c < MAXC; c++) begin
      ev_v[inst][c]  = 1'b0;
      ev_hi[inst][c] = 0;
      ev_lo[inst][c] = 0;
      ev_to[inst][c] = 1'b0;
    end
    for (int k = 1; k <= n_cyc; k++)
      if (wave[k] != wave[k-1]) edges.push_back(k);
    for (int i = 0; i < edges.size(); i++) begin
      e   = edges[i];
      nxt = (i + 1 < edges.size()) ? edges[i+1] : 2 * MAXC;
      // A rise closes a period when the fall and rise before it bound two
      // phases that both fit the counter and the opening rise was genuine.
      if (wave[e] == 1 && i >= 2) begin
        r = edges[i-2];
        f = edges[i-1];
        if (r >= 2 && f - r <= mx && e - f <= mx && e + s < MAXC) begin
          ev_v[inst][e+s]  = 1'b1;
          ev_hi[inst][e+s] = f - r;
          ev_lo[inst][e+s] = e - f;
        end
      end
      // Every rise starts a timed phase; a fall does so only if the high
      // phase before it did not already time out.
      tracked = (wave[e] == 1) || (e - edges[i-1] <= mx);
      if (tracked && nxt > e + mx && e + mx + s < MAXC)
        ev_to[inst][e+mx+s] = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/d%0d/ht", tag, i), o_ht[i], 0);
      check($sformatf("%s/d%0d/lt", tag, i), o_lt[i], 0);
      check($sformatf("%s/d%0d/pd", tag, i), o_pd[i], 0);
      check($sformatf("%s/d%0d/valid", tag, i), o_v[i], 0);
      check($sformatf("%s/d%0d/timeout", tag, i), o_to[i], 0);
    end
  endtask

  task automatic run_segment(input string name);
    int last_hi[3], last_lo[3];
    bit exp_to[3];
    bit exp_v;
    for (int i = 0; i < 3; i++) begin
      build_model(i);
      last_hi[i] = 0;
      last_lo[i] = 0;
      exp_to[i]  = 1'b0;
    end
    rst_n  = 1'b0;
    sig_in = wave[1][0];
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_zero({name, "/rst"});
    rst_n = 1'b1;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      for (int i = 0; i < 3; i++) begin
        exp_v = ev_v[i][k];
        if (exp_v) begin
          last_hi[i] = ev_hi[i][k];
          last_lo[i] = ev_lo[i][k];
          exp_to[i]  = 1'b0;
        end
        if (ev_to[i][k]) exp_to[i] = 1'b1;
        check($sformatf("%s/d%0d/c%0d/valid", name, i, k), o_v[i], exp_v);
        check($sformatf("%s/d%0d/c%0d/ht", name, i, k), o_ht[i], last_hi[i]);
        check($sformatf("%s/d%0d/c%0d/lt", name, i, k), o_lt[i], last_lo[i]);
        check($sformatf("%s/d%0d/c%0d/pd", name, i, k), o_pd[i], last_hi[i] + last_lo[i]);
        check($sformatf("%s/d%0d/c%0d/timeout", name, i, k), o_to[i], exp_to[i]);
      end
      if (k < n_cyc) sig_in = wave[k+1][0];
    end
  endtask

  initial begin
    // Divide-by-6: 3 high, 3 low
    new_wave();
    add_phase(0, 4);
    for (int t = 0; t < 12; t++) begin add_phase(1, 3); add_phase(0, 3); end
    run_segment("div6");

    // 2 high, 5 low
    new_wave();
    add_phase(0, 2);
    for (int t = 0; t < 10; t++) begin add_phase(1, 2); add_phase(0, 5); end
    run_segment("h2l5");

    // Toggle every cycle: minimum one-cycle phases
    new_wave();
    add_phase(0, 1);
    for (int t = 0; t < 30; t++) begin add_phase(1, 1); add_phase(0, 1); end
    run_segment("toggle");

    // Long high phase (times out the 4-bit instance), then 3/3
    new_wave();
    add_phase(0, 2);
    add_phase(1, 20);
    for (int t = 0; t < 6; t++) begin add_phase(0, 3); add_phase(1, 3); end
    add_phase(0, 3);
    run_segment("hold");

    // Input already high at reset release: truncated first phase
    new_wave();
    add_phase(1, 5);
    add_phase(0, 3);
    for (int t = 0; t < 5; t++) begin add_phase(1, 3); add_phase(0, 3); end
    run_segment("trunc");

    // Random phase lengths, some beyond the 4-bit counter range
    new_wave();
    add_phase(0, 3);
    for (int t = 0; t < 40; t++) begin
      add_phase(1, int'($urandom_range(1, 20)));
      add_phase(0, int'($urandom_range(1, 20)));
    end
    run_segment("rand");

    // Reset pulsed between clock edges while in the low phase
    new_wave();
    add_phase(0, 2);
    for (int t = 0; t < 8; t++) begin add_phase(1, 3); add_phase(0, 3); end
    add_phase(0, 1);
    run_segment("rstmid");
    #2 rst_n = 1'b0;
    #1 check_zero("async");

    // Fresh measurement after the asynchronous reset
    new_wave();
    add_phase(0, 3);
    for (int t = 0; t < 6; t++) begin add_phase(1, 4); add_phase(0, 2); end
    run_segment("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
